// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: operand/opcode formation with writeback forwarding
// Optional feature macro: ALU_ISSUE_SKID_EN (two-entry skid buffer, registered o_READY).
// Default build: single output register, o_READY = !o_VALID || i_READY.
module alu_issue_stage #(
  parameter int DEPTH_LOG2 = 1
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_VALID,
  output logic        o_READY,
  input  logic [6:0]  i_OPC,
  input  logic [2:0]  i_FUNCT3,
  input  logic        i_FUNCT7B5,
  input  logic [4:0]  i_RS1,
  input  logic [4:0]  i_RS2,
  input  logic [31:0] i_RS1_DATA,
  input  logic [31:0] i_RS2_DATA,
  input  logic [31:0] i_IMM,
  input  logic [31:0] i_PC,
  input  logic        i_FWD_VALID,
  input  logic [4:0]  i_FWD_RD,
  input  logic [31:0] i_FWD_DATA,
  input  logic        i_FLUSH,
  output logic        o_VALID,
  input  logic        i_READY,
  output logic [31:0] o_OP1,
  output logic [31:0] o_OP2,
  output logic [8:0]  o_OPCODE,
  output logic        o_ILLEGAL
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [8:0] ALU_ADD    = 9'h001;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [8:0]  opc;
    logic        ill;
  } entry_t;

  entry_t head;
  entry_t cap;
  logic   accept;
  logic   consume;

  // Writeback result wins over the register file; x0 always reads as zero
  function automatic logic [31:0] fwd_sel(input logic [4:0] rs, input logic [31:0] rf);
    if (i_FWD_VALID && (i_FWD_RD != 5'd0) && (i_FWD_RD == rs)) return i_FWD_DATA;
    else if (rs == 5'd0) return 32'd0;
    else return rf;
  endfunction

  // Form the entry captured on an accept: operands, one-hot opcode, illegal flag
  always_comb begin
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [8:0]  alu;
    logic        is_shift;
    rs1v     = fwd_sel(i_RS1, i_RS1_DATA);
    rs2v     = fwd_sel(i_RS2, i_RS2_DATA);
    is_shift = (i_FUNCT3 == 3'b001) || (i_FUNCT3 == 3'b101);
    // SRA/SRAI reuse the slot at bit 2 with the modifier bit set
    if ((i_FUNCT3 == 3'b101) && i_FUNCT7B5) alu = 9'h104;
    else alu = {1'b0, 8'b1 << i_FUNCT3};
    cap = '0;
    case (i_OPC)
      OPC_OP: begin
        cap.op1 = rs1v;
        cap.op2 = is_shift ? {27'd0, rs2v[4:0]} : rs2v;
        cap.opc = alu;
        if (i_FUNCT3 == 3'b000) cap.opc[8] = i_FUNCT7B5;
      end
      OPC_OPIMM: begin
        cap.op1 = rs1v;
        cap.op2 = is_shift ? {27'd0, i_IMM[4:0]} : i_IMM;
        cap.opc = alu;
      end
      OPC_LOAD, OPC_STORE: begin
        cap.op1 = rs1v;
        cap.op2 = i_IMM;
        cap.opc = ALU_ADD;
      end
      OPC_LUI: begin
        cap.op2 = i_IMM;
        cap.opc = ALU_ADD;
      end
      OPC_AUIPC: begin
        cap.op1 = i_PC;
        cap.op2 = i_IMM;
        cap.opc = ALU_ADD;
      end
      default: cap.ill = 1'b1;
    endcase
  end

  assign accept    = i_VALID && o_READY;
  assign consume   = o_VALID && i_READY;
  assign o_OP1     = head.op1;
  assign o_OP2     = head.op2;
  assign o_OPCODE  = head.opc;
  assign o_ILLEGAL = head.ill;

`ifdef ALU_ISSUE_SKID_EN
  localparam int CW = DEPTH_LOG2 + 1;

  entry_t        slot1;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          rdy_q;

  assign o_READY = rdy_q;

  // Occupancy after this cycle's push/pop; flush empties everything
  always_comb begin
    cnt_n = cnt;
    if (accept)  cnt_n = cnt_n + 1'b1;
    if (consume) cnt_n = cnt_n - 1'b1;
    if (i_FLUSH) cnt_n = '0;
  end

  // Head always holds the oldest entry; slot1 only fills while head is stalled
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      head    <= '0;
      slot1   <= '0;
      cnt     <= '0;
      o_VALID <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      if (!i_FLUSH) begin
        if (consume) begin
          if (cnt == CW'(2)) head <= slot1;
          else if (accept) head <= cap;
        end else if (accept) begin
          if (cnt == '0) head <= cap;
          else slot1 <= cap;
        end
      end
      cnt     <= cnt_n;
      o_VALID <= (cnt_n != '0);
      rdy_q   <= (cnt_n < CW'(2));
    end
  end
`else
  assign o_READY = !o_VALID || i_READY;

  // Single output register, replaced back-to-back when the ALU consumes
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      head    <= '0;
      o_VALID <= 1'b0;
    end else if (i_FLUSH) begin
      o_VALID <= 1'b0;
    end else if (accept) begin
      head    <= cap;
      o_VALID <= 1'b1;
    end else if (consume) begin
      o_VALID <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic        rdy_o;
  logic [6:0]  opc = '0;
  logic [2:0]  f3 = '0;
  logic        b5 = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic [31:0] d1 = '0, d2 = '0, imm = '0, pc = '0;
  logic        fv = 1'b0;
  logic [4:0]  frd = '0;
  logic [31:0] fd = '0;
  logic        flush = 1'b0;
  logic        vout;
  logic        rdy_i = 1'b1;
  logic [31:0] op1, op2;
  logic [8:0]  opcode;
  logic        ill;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [8:0]  o;
    logic        i;
  } exp_t;

  exp_t q[$];

  alu_issue_stage dut (
    .i_CLK(clk), .i_RST(rst), .i_VALID(vin), .o_READY(rdy_o),
    .i_OPC(opc), .i_FUNCT3(f3), .i_FUNCT7B5(b5),
    .i_RS1(rs1), .i_RS2(rs2), .i_RS1_DATA(d1), .i_RS2_DATA(d2),
    .i_IMM(imm), .i_PC(pc),
    .i_FWD_VALID(fv), .i_FWD_RD(frd), .i_FWD_DATA(fd),
    .i_FLUSH(flush), .o_VALID(vout), .i_READY(rdy_i),
    .o_OP1(op1), .o_OP2(op2), .o_OPCODE(opcode), .o_ILLEGAL(ill)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] o, input logic [2:0] f, input logic b,
                        input logic [4:0] r1, input logic [31:0] x1,
                        input logic [4:0] r2, input logic [31:0] x2, input logic [31:0] im);
    opc = o; f3 = f; b5 = b; rs1 = r1; d1 = x1; rs2 = r2; d2 = x2; imm = im;
    pc = 32'h0000_1000; fv = 1'b0; frd = 5'd0; fd = 32'd0; flush = 1'b0; vin = 1'b1;
  endtask

  task automatic idle();
    vin = 1'b0; fv = 1'b0; flush = 1'b0;
  endtask

  // Reference: operand value seen by an instruction reading register r
  function automatic logic [31:0] ref_src(input logic [4:0] r, input logic [31:0] rf);
    if (fv && frd == r && frd != 0) return fd;
    return (r == 0) ? 32'd0 : rf;
  endfunction

  // Reference: what the ALU should receive for the currently driven instruction
  function automatic exp_t ref_entry();
    exp_t e;
    int   sh;
    logic [31:0] a, b;
    a = ref_src(rs1, d1);
    b = ref_src(rs2, d2);
    e = '0;
    sh = (f3 == 1 || f3 == 5);
    if (opc == 7'h33 || opc == 7'h13) begin
      e.a = a;
      e.b = (opc == 7'h33) ? b : imm;
      if (sh) e.b = e.b % 32;
      if (f3 == 5 && b5) e.o = 9'h104;
      else e.o = 9'(1 << f3) + ((opc == 7'h33 && f3 == 0 && b5) ? 9'd256 : 9'd0);
    end else if (opc == 7'h03 || opc == 7'h23) begin
      e.a = a; e.b = imm; e.o = 9'd1;
    end else if (opc == 7'h37) begin
      e.b = imm; e.o = 9'd1;
    end else if (opc == 7'h17) begin
      e.a = pc; e.b = imm; e.o = 9'd1;
    end else begin
      e.i = 1'b1;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({vout, op1, op2, opcode, ill} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b op1=%h op2=%h opc=%h ill=%0b want all 0", vout, op1, op2, opcode, ill);
    end
    checks++;
    if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", rdy_o); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_add_sub();
    rdy_i = 1'b1;
    set_op(7'h33, 3'b000, 1'b1, 5'd7, 32'd7, 5'd3, 32'd3, 32'd0);
    step();
    checks++;
    if ({vout, opcode, op1, op2} !== {1'b1, 9'h101, 32'd7, 32'd3}) begin
      errors++;
      $display("FAIL sub got v=%0b opc=%h op1=%h op2=%h want v=1 opc=101 op1=7 op2=3", vout, opcode, op1, op2);
    end
    set_op(7'h33, 3'b000, 1'b0, 5'd7, 32'd7, 5'd3, 32'd3, 32'd0);
    step();
    checks++;
    if (opcode !== 9'h001) begin errors++; $display("FAIL add got opc=%h want 001", opcode); end
    idle();
    step();
  endtask

  task automatic test_addi();
    set_op(7'h13, 3'b000, 1'b1, 5'd1, 32'd10, 5'd0, 32'd0, -32'sd1024);
    step();
    checks++;
    if ({opcode, op1, op2} !== {9'h001, 32'd10, 32'hFFFF_FC00}) begin
      errors++;
      $display("FAIL addi got opc=%h op1=%h op2=%h want 001 0000000a fffffc00", opcode, op1, op2);
    end
    idle();
    step();
  endtask

  task automatic test_sra_slt();
    set_op(7'h13, 3'b101, 1'b1, 5'd2, 32'h8000_0000, 5'd0, 32'd0, 32'h0000_0405);
    step();
    checks++;
    if ({opcode, op2} !== {9'h104, 32'd5}) begin
      errors++; $display("FAIL srai got opc=%h op2=%h want 104 00000005", opcode, op2);
    end
    set_op(7'h13, 3'b010, 1'b0, 5'd2, 32'd1, 5'd0, 32'd0, 32'd9);
    step();
    checks++;
    if (opcode !== 9'h004) begin errors++; $display("FAIL slti got opc=%h want 004", opcode); end
    set_op(7'h33, 3'b101, 1'b0, 5'd2, 32'd1, 5'd4, 32'h0000_0123, 32'd0);
    step();
    checks++;
    if ({opcode, op2} !== {9'h020, 32'd3}) begin
      errors++; $display("FAIL srl got opc=%h op2=%h want 020 00000003", opcode, op2);
    end
    idle();
    step();
  endtask

  task automatic test_forward();
    set_op(7'h33, 3'b000, 1'b0, 5'd5, 32'd1, 5'd6, 32'd2, 32'd0);
    fv = 1'b1; frd = 5'd5; fd = 32'h0000_ABCD;
    rdy_i = 1'b0;
    step();
    checks++;
    if ({op1, op2} !== {32'h0000_ABCD, 32'd2}) begin
      errors++; $display("FAIL fwd_rs1 got op1=%h op2=%h want 0000abcd 00000002", op1, op2);
    end
    idle();
    fv = 1'b1; frd = 5'd5; fd = 32'h1111_2222;
    step();
    checks++;
    if (op1 !== 32'h0000_ABCD) begin errors++; $display("FAIL fwd_held got op1=%h want 0000abcd", op1); end
    rdy_i = 1'b1;
    step();
    set_op(7'h33, 3'b000, 1'b0, 5'd0, 32'h55, 5'd6, 32'd2, 32'd0);
    fv = 1'b1; frd = 5'd0; fd = 32'h0000_ABCD;
    step();
    checks++;
    if (op1 !== 32'd0) begin errors++; $display("FAIL fwd_x0 got op1=%h want 0", op1); end
    idle();
    step();
  endtask

  task automatic test_illegal();
    set_op(7'b1110011, 3'b000, 1'b0, 5'd1, 32'd7, 5'd2, 32'd8, 32'd4);
    step();
    checks++;
    if ({vout, ill, opcode, op1, op2} !== {1'b1, 1'b1, 9'h000, 64'd0}) begin
      errors++;
      $display("FAIL illegal got v=%0b ill=%0b opc=%h op1=%h op2=%h want 1 1 000 0 0", vout, ill, opcode, op1, op2);
    end
    idle();
    step();
  endtask

  task automatic test_flush();
    rdy_i = 1'b0;
    set_op(7'h37, 3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h1234_5000);
    step();
    set_op(7'h17, 3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd4);
    flush = 1'b1;
    step();
    checks++;
    if ({vout, rdy_o} !== 2'b01) begin
      errors++; $display("FAIL flush got v=%0b rdy=%0b want v=0 rdy=1", vout, rdy_o);
    end
    idle();
    rdy_i = 1'b1;
    step();
  endtask

  task automatic test_backpressure();
    rdy_i = 1'b0;
    set_op(7'h37, 3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'hA);
    step();
    set_op(7'h37, 3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'hB);
`ifdef ALU_ISSUE_SKID_EN
    step();
    set_op(7'h37, 3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'hC);
    #1;
`else
    #1;
`endif
    checks++;
    if ({rdy_o, vout, op2} !== {1'b0, 1'b1, 32'hA}) begin
      errors++; $display("FAIL bp_full got rdy=%0b v=%0b op2=%h want 0 1 a", rdy_o, vout, op2);
    end
    step();
    checks++;
    if (op2 !== 32'hA) begin errors++; $display("FAIL bp_stable got op2=%h want a", op2); end
    idle();
    rdy_i = 1'b1;
    step();
`ifdef ALU_ISSUE_SKID_EN
    checks++;
    if ({vout, op2} !== {1'b1, 32'hB}) begin
      errors++; $display("FAIL bp_drain2 got v=%0b op2=%h want 1 b", vout, op2);
    end
    step();
`endif
    checks++;
    if ({vout, rdy_o} !== 2'b01) begin
      errors++; $display("FAIL bp_empty got v=%0b rdy=%0b want 0 1", vout, rdy_o);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs [8];
    logic       exp_rdy;
    exp_t       e;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h33};
    q.delete();
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (vout !== (q.size() != 0)) begin
        errors++; $display("FAIL rand_valid cyc=%0d got %0b want %0b", n, vout, q.size() != 0);
      end else if (q.size() != 0) begin
        checks++;
        if ({op1, op2, opcode, ill} !== q[0]) begin
          errors++;
          $display("FAIL rand_data cyc=%0d got %h %h %h %0b want %h %h %h %0b", n, op1, op2, opcode, ill,
                   q[0].a, q[0].b, q[0].o, q[0].i);
        end
      end
      vin   = ($urandom_range(0, 3) != 0);
      rdy_i = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      opc   = opcs[$urandom_range(0, 7)];
      f3    = 3'($urandom);
      b5    = 1'($urandom);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      d1    = $urandom; d2 = $urandom; imm = $urandom; pc = $urandom;
      fv    = 1'($urandom);
      frd   = 5'($urandom_range(0, 3));
      fd    = $urandom;
      #1;
`ifdef ALU_ISSUE_SKID_EN
      exp_rdy = (q.size() < 2);
`else
      exp_rdy = (q.size() == 0) || rdy_i;
`endif
      checks++;
      if (rdy_o !== exp_rdy) begin
        errors++; $display("FAIL rand_ready cyc=%0d got %0b want %0b", n, rdy_o, exp_rdy);
      end
      e = ref_entry();
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && rdy_i) void'(q.pop_front());
        if (vin && exp_rdy) q.push_back(e);
      end
      step();
    end
    idle();
    rdy_i = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset_midstream();
    rdy_i = 1'b0;
    set_op(7'h17, 3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd8);
    step();
    idle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({vout, op1, op2, opcode, ill, rdy_o} !== {75'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got v=%0b op1=%h op2=%h opc=%h ill=%0b rdy=%0b want 0s rdy=1",
               vout, op1, op2, opcode, ill, rdy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    rdy_i = 1'b1;
    step();
    checks++;
    if (vout !== 1'b0) begin errors++; $display("FAIL reset_mid_after got v=%0b want 0", vout); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_addi();
    test_sra_slt();
    test_forward();
    test_illegal();
    test_flush();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-entry stage placed directly upstream of the ALU. Accepts decoded RV32I instructions from decode over a valid/ready handshake, then forms the two ALU operands (register, immediate, PC or zero) with writeback forwarding. Builds the ALU's 9-bit opcode: one-hot `funct3` in bits [7:0], modifier in bit 8. Presents all of these from registers so the ALU sees stable inputs for a full cycle.

## Interface
- `DEPTH_LOG2`, default 1: log2 of the skid buffer depth; used only when the skid feature is compiled in (fixed 2 entries).
- `i_CLK` input 1: the single clock.
- `i_RST` input 1: asynchronous, active-high reset.
- `i_VALID` input 1: decode presents an instruction.
- `o_READY` output 1: stage can accept this cycle.
- `i_OPC` input 7: RV32I major opcode.
- `i_FUNCT3` input 3: funct3 field.
- `i_FUNCT7B5` input 1: instruction bit 30.
- `i_RS1`, `i_RS2` input 5 each: source register indices.
- `i_RS1_DATA`, `i_RS2_DATA` input 32 each: register-file read data.
- `i_IMM` input 32: sign-extended immediate.
- `i_PC` input 32: instruction PC.
- `i_FWD_VALID` input 1: writeback result valid.
- `i_FWD_RD` input 5: writeback destination register.
- `i_FWD_DATA` input 32: writeback result.
- `i_FLUSH` input 1: synchronous discard of all held instructions.
- `o_VALID` output 1: outputs hold a valid instruction.
- `i_READY` input 1: ALU/downstream consumes this cycle.
- `o_OP1`, `o_OP2` output 32 each: ALU operands.
- `o_OPCODE` output 9: ALU opcode.
- `o_ILLEGAL` output 1: held instruction has an unsupported major opcode.

## Operation
- Transfer in happens when `i_VALID && o_READY`. Transfer out happens when `o_VALID && i_READY`.
- Forwarding is resolved at capture:
  - If `i_FWD_VALID`, `i_FWD_RD != 0` and `i_FWD_RD == i_RSx`, use `i_FWD_DATA`.
  - Otherwise, if `i_RSx == 0`, use 0.
  - Otherwise, use `i_RSx_DATA`.
- Operand and opcode selection by `i_OPC`:
  - OP (0110011): OP1 = rs1, OP2 = rs2.
  - OP-IMM (0010011): OP1 = rs1, OP2 = imm.
  - LOAD (0000011) and STORE (0100011): OP1 = rs1, OP2 = imm, opcode forced to ADD.
  - LUI (0110111): OP1 = 0, OP2 = imm, ADD.
  - AUIPC (0010111): OP1 = PC, OP2 = imm, ADD.
  - Any other value: OP1 = OP2 = 0, `o_OPCODE` = 0, `o_ILLEGAL` = 1.
- Opcode one-hot, `f3` = `i_FUNCT3`:
  - `f3 == 101` with `i_FUNCT7B5 == 1` (SRA/SRAI): bits[7:0] = 1<<2, bit8 = 1.
  - `f3 == 010` (SLT/SLTI): bits[7:0] = 1<<2, bit8 = 0.
  - All other `f3`: bits[7:0] = 1<<`f3`.
- Opcode bit 8:
  - Set to `i_FUNCT7B5` for OP with `f3 == 000` (SUB).
  - Set to 1 for SRA/SRAI as above.
  - 0 in every other case, including ADDI regardless of imm[10].
- Shift amount: when `f3` is 001 or 101 (OP or OP-IMM), OP2 is masked to bits [4:0], zero-extended.
- `i_FLUSH` empties the stage. It takes priority over a simultaneous accept: the incoming instruction is dropped and `o_VALID` is 0 next cycle.

## Timing
- Reset (asynchronous): `o_VALID` = 0, `o_OP1` = `o_OP2` = 0, `o_OPCODE` = 0, `o_ILLEGAL` = 0, buffer empty.
- `o_READY` reset value depends on the configuration (see below).
- Latency: an instruction accepted in cycle N appears at the outputs in cycle N+1.
- Outputs are stable while `o_VALID && !i_READY`.
- Reset mid-stream discards all entries.
- Forwarding samples `i_FWD_*` only in the accept cycle; a later writeback does not update a held operand.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Two-entry skid buffer.
  - `o_READY` is a register equal to "fewer than 2 entries held"; it has no combinational path from `i_READY`.
  - Reset value of `o_READY` is 1.
  - Full buffer: `o_READY` = 0.
  - Simultaneous accept and consume while full cannot occur, because `o_READY` was 0.
  - With 1 entry held, simultaneous accept and consume keeps the count at 1.
  - Outputs always show the oldest entry.
- `ALU_ISSUE_SKID_EN` undefined:
  - Single output register.
  - `o_READY = !o_VALID || i_READY`, combinational.
  - Reset value of `o_READY` is 1.
  - Full throughput with back-to-back replace.

## Test plan
- ADD/SUB: OP, f3 = 000, B5 = 1, rs1 = 7, rs2 = 3 -> next cycle `o_OPCODE` = 9'h101, OP1 = 7, OP2 = 3.
- ADDI vs SUB: OP-IMM, f3 = 000, B5 = 1 (imm = -1024) -> `o_OPCODE` = 9'h001.
- SRAI/SLT mapping: SRAI, imm = 32'h0000_0405 -> `o_OPCODE` = 9'h104, OP2 = 5. SLTI -> `o_OPCODE` = 9'h004.
- Forwarding: rs1 = 5, `i_RS1_DATA` = 1, `i_FWD_RD` = 5, `i_FWD_DATA` = 0xABCD -> OP1 = 0xABCD. Same with rs1 = 0 and `i_FWD_RD` = 0 -> OP1 = 0.
- Backpressure (skid enabled): hold `i_READY` = 0 and feed 3 instructions -> two are accepted, `o_READY` = 0. Then release -> they drain in order and `o_READY` returns to 1.
- Flush/illegal:
  - Opcode 1110011 -> `o_ILLEGAL` = 1, `o_OPCODE` = 0.
  - `i_FLUSH` together with `i_VALID` -> next cycle `o_VALID` = 0.
  - `i_RST` asserted mid-stream -> all outputs 0 immediately.
